half_subtractor: RTL and testbench

Registered, lane-parallel half subtractor. Each bit lane computes `a − b` for one-bit operands and produces the difference, the borrow, and the complement of the minuend. The block is a leaf arithmetic primitive: it feeds borrow-chain and comparator logic downstream, and its outputs are registered on a single clock domain.

---
 rtl/half_subtractor.sv | 87 ++++++++
 tb/tb_half_subtractor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/half_subtractor.sv
// half_subtractor: lane-parallel one-bit subtractors with optional output register.
// Each lane computes a - b as (difference, borrow) and also presents NOT a.
// Lanes are fully independent; nothing ripples between them.
module half_subtractor #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] n_out,
    output logic             valid_out
);

    // Per-lane subtraction. Difference is a XOR b, borrow is raised only when
    // b exceeds a, so that a - b == d - 2*borrow holds in every lane.
    function automatic logic [3*WIDTH-1:0] lane_sub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] brw;
        logic [WIDTH-1:0] n;
        d   = a ^ b;
        brw = ~a & b;
        n   = ~a;
        return {d, brw, n};
    endfunction

    logic [WIDTH-1:0] d_p0;
    logic [WIDTH-1:0] brw_p0;
    logic [WIDTH-1:0] n_p0;
    logic             vld_p0;

    // Stage 0: combinational lane results straight from the inputs.
    always_comb begin
        {d_p0, brw_p0, n_p0} = lane_sub(a_in, b_in);
        vld_p0               = valid_in;
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [WIDTH-1:0] d_p1;
            logic [WIDTH-1:0] brw_p1;
            logic [WIDTH-1:0] n_p1;
            logic             vld_p1;

            // Stage 1: capture qualified results; idle cycles hold the data and
            // only drop valid. Reset forces the a=0 view (n all ones), so the
            // outputs stay self-consistent while nothing is valid.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    d_p1   <= '0;
                    brw_p1 <= '0;
                    n_p1   <= '1;
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        d_p1   <= d_p0;
                        brw_p1 <= brw_p0;
                        n_p1   <= n_p0;
                    end
                end
            end

            assign d_out     = d_p1;
            assign b_out     = brw_p1;
            assign n_out     = n_p1;
            assign valid_out = vld_p1;
        end else begin : g_comb
            // Clock and reset play no part in the combinational variant.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk_in, rst_in};

            assign d_out     = d_p0;
            assign b_out     = brw_p0;
            assign n_out     = n_p0;
            assign valid_out = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_half_subtractor.sv
// tb_half_subtractor: directed checks of the combinational, 1-lane registered
// and 8-lane registered variants of half_subtractor.
module tb_half_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Combinational, single lane
    logic       c_v, c_a, c_b;
    logic       c_d, c_bo, c_n, c_vo;
    // Registered, single lane
    logic       r1_v, r1_a, r1_b;
    logic       r1_d, r1_bo, r1_n, r1_vo;
    // Registered, eight lanes
    logic       r8_v;
    logic [7:0] r8_a, r8_b;
    logic [7:0] r8_d, r8_bo, r8_n;
    logic       r8_vo;

    half_subtractor #(.WIDTH(1), .REGISTERED(0)) u_comb (
        .clk_in(clk), .rst_in(rst), .valid_in(c_v), .a_in(c_a), .b_in(c_b),
        .d_out(c_d), .b_out(c_bo), .n_out(c_n), .valid_out(c_vo)
    );

    half_subtractor #(.WIDTH(1), .REGISTERED(1)) u_r1 (
        .clk_in(clk), .rst_in(rst), .valid_in(r1_v), .a_in(r1_a), .b_in(r1_b),
        .d_out(r1_d), .b_out(r1_bo), .n_out(r1_n), .valid_out(r1_vo)
    );

    half_subtractor #(.WIDTH(8), .REGISTERED(1)) u_r8 (
        .clk_in(clk), .rst_in(rst), .valid_in(r8_v), .a_in(r8_a), .b_in(r8_b),
        .d_out(r8_d), .b_out(r8_bo), .n_out(r8_n), .valid_out(r8_vo)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference built from integer subtraction per lane, not from gate equations.
    function automatic logic [23:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d, bo, n;
        int diff;
        for (int k = 0; k < 8; k++) begin
            diff  = int'(a[k]) - int'(b[k]);
            bo[k] = (diff < 0);
            d[k]  = (diff != 0);
            n[k]  = (a[k] == 1'b0);
        end
        return {d, bo, n};
    endfunction

    // Per-lane check of a - b == d - 2*borrow.
    function automatic bit ident_ok(input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] d, input logic [7:0] bo);
        bit ok = 1'b1;
        for (int k = 0; k < 8; k++)
            if (int'(d[k]) - 2 * int'(bo[k]) != int'(a[k]) - int'(b[k])) ok = 1'b0;
        return ok;
    endfunction

    logic [2:0]  tt_exp [4] = '{3'b001, 3'b111, 3'b100, 3'b000};
    logic [7:0]  pa, pb;
    logic [23:0] rexp;
    logic [1:0]  ab;

    initial begin
        c_v = 1'b0; c_a = 1'b0; c_b = 1'b0;
        r1_v = 1'b0; r1_a = 1'b0; r1_b = 1'b0;
        r8_v = 1'b0; r8_a = '0; r8_b = '0;
        pa = '0; pb = '0;

        // Reset values, with a clock edge already seen under reset
        #12;
        check("r1_rst_d", r1_d, 1'b0);
        check("r1_rst_b", r1_bo, 1'b0);
        check("r1_rst_n", r1_n, 1'b1);
        check("r1_rst_v", r1_vo, 1'b0);
        check("r8_rst_dbn", {r8_d, r8_bo, r8_n}, 24'h0000FF);
        check("r8_rst_v", r8_vo, 1'b0);

        // Combinational truth table (reset still high: must not matter)
        for (int i = 0; i < 4; i++) begin
            ab  = 2'(i);
            c_a = ab[1];
            c_b = ab[0];
            c_v = ab[0];
            #10;
            check($sformatf("tt_%0d%0d", c_a, c_b), {c_d, c_bo, c_n}, tt_exp[i]);
            check($sformatf("tt_v_%0d", i), c_vo, ab[0]);
            check($sformatf("tt_ident_%0d", i),
                  ident_ok({7'd0, c_a}, {7'd0, c_b}, {7'd0, c_d}, {7'd0, c_bo}), 1'b1);
        end

        @(negedge clk);
        rst = 1'b0;

        // Registered latency, single lane
        r1_a = 1'b1; r1_b = 1'b0; r1_v = 1'b1;
        @(negedge clk);
        check("lat_dbn", {r1_d, r1_bo, r1_n}, 3'b100);
        check("lat_v", r1_vo, 1'b1);
        r1_v = 1'b0; r1_a = 1'b0; r1_b = 1'b1;
        @(negedge clk);
        check("hold_v", r1_vo, 1'b0);
        check("hold_dbn", {r1_d, r1_bo, r1_n}, 3'b100);

        // Multi-lane
        r8_a = 8'hA5; r8_b = 8'h3C; r8_v = 1'b1;
        @(negedge clk);
        check("ml_d", r8_d, 8'h99);
        check("ml_b", r8_bo, 8'h18);
        check("ml_n", r8_n, 8'h5A);
        check("ml_v", r8_vo, 1'b1);

        // Asynchronous reset between edges
        r8_a = 8'hFF; r8_b = 8'h00;
        @(negedge clk);
        check("ar_pre_d", r8_d, 8'hFF);
        check("ar_pre_v", r8_vo, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("ar_imm_dbn", {r8_d, r8_bo, r8_n}, 24'h0000FF);
        check("ar_imm_v", r8_vo, 1'b0);
        @(negedge clk);
        check("ar_held_dbn", {r8_d, r8_bo, r8_n}, 24'h0000FF);
        rst = 1'b0;
        #1;
        check("ar_rel_dbn", {r8_d, r8_bo, r8_n}, 24'h0000FF);
        check("ar_rel_v", r8_vo, 1'b0);
        @(negedge clk);
        check("ar_cap_dbn", {r8_d, r8_bo, r8_n}, 24'hFF0000);
        check("ar_cap_v", r8_vo, 1'b1);

        // Back-to-back streaming of 16 random pairs
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                rexp = ref_sub(pa, pb);
                check($sformatf("st_dbn_%0d", i), {r8_d, r8_bo, r8_n}, rexp);
                check($sformatf("st_v_%0d", i), r8_vo, 1'b1);
                check($sformatf("st_ident_%0d", i), ident_ok(pa, pb, r8_d, r8_bo), 1'b1);
            end
            if (i < 16) begin
                pa   = 8'($urandom);
                pb   = 8'($urandom);
                r8_a = pa;
                r8_b = pb;
                r8_v = 1'b1;
            end
            @(negedge clk);
        end
        r8_v = 1'b0;
        @(negedge clk);
        check("st_end_v", r8_vo, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
